// File: rtl/pipeline_fetch.sv
// rtl/pipeline_fetch.sv - RV32I fetch stage: PC, single-outstanding imem read, fetch buffer
module pipeline_fetch #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_ready,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic [XLEN-1:0] instrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPLUS4F,
   output logic            o_validF
);

   // S_REQ: ready to issue; S_WAIT: read in flight, keep data; S_DROP: read in flight, discard data
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pcf_q, pcf_d;
   logic [XLEN-1:0] pcplus4_q, pcplus4_d;

   logic            consume;
   logic            buf_free;
   logic            imem_req;
   logic            capture;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_pc;

   // Decode takes the buffered word this cycle; the buffer is free if empty or being drained
   assign consume     = valid_q & ~i_stall;
   assign buf_free    = ~valid_q | consume;
   assign pc_plus4    = pc_q + XLEN'(4);
   assign redirect_pc = i_redirect_pc & ~XLEN'(3);

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a redirect while waiting turns the in-flight read into one to discard
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_REQ: begin
            if (imem_req && i_imem_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_redirect) begin
               // a response landing with the redirect is already spent, so nothing is left to drop
               state_d = i_imem_rvalid ? S_REQ : S_DROP;
            end else if (capture) begin
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (i_imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // FSM outputs: issue only when the buffer will be free; capture only a live response
   always_comb begin
      imem_req = 1'b0;
      capture  = 1'b0;
      unique case (state_q)
         S_REQ: begin
            imem_req = buf_free & ~i_redirect & ~i_rst;
         end
         S_WAIT: begin
            capture = i_imem_rvalid & buf_free & ~i_redirect;
         end
         default: begin
            imem_req = 1'b0;
            capture  = 1'b0;
         end
      endcase
   end

   // Datapath next values: redirect beats capture, capture beats drain
   always_comb begin
      pc_d      = pc_q;
      valid_d   = valid_q;
      instr_d   = instr_q;
      pcf_d     = pcf_q;
      pcplus4_d = pcplus4_q;
      if (i_redirect) begin
         pc_d    = redirect_pc;
         valid_d = 1'b0;
      end else if (capture) begin
         instr_d   = i_imem_rdata;
         pcf_d     = pc_q;
         pcplus4_d = pc_plus4;
         valid_d   = 1'b1;
         pc_d      = pc_plus4;
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   // Datapath registers: PC and fetch buffer
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q      <= RESET_PC;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         pcf_q     <= '0;
         pcplus4_q <= '0;
      end else begin
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         pcf_q     <= pcf_d;
         pcplus4_q <= pcplus4_d;
      end
   end

   assign o_imem_req  = imem_req;
   assign o_imem_addr = pc_q;
   assign instrF      = instr_q;
   assign PCF         = pcf_q;
   assign PCPLUS4F    = pcplus4_q;
   assign o_validF    = valid_q;

endmodule

// File: tb/tb_pipeline_fetch.sv
// tb/tb_pipeline_fetch.sv - randomized bench for pipeline_fetch with a transaction-level model
module tb_pipeline_fetch;

   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_stall = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ready = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic [31:0] instrF;
   logic [31:0] PCF;
   logic [31:0] PCPLUS4F;
   logic        o_validF;

   pipeline_fetch #(.XLEN(32), .RESET_PC(RPC)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ready  (i_imem_ready),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .instrF        (instrF),
      .PCF           (PCF),
      .PCPLUS4F      (PCPLUS4F),
      .o_validF      (o_validF)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: expected next fetch address, buffer contents, and the memory's one pending read
   logic [31:0] exp_pc = RPC;
   bit          m_valid = 1'b0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_instr = '0;
   int          epoch = 0;
   bit          pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          pend_epoch = 0;
   int          pend_dly = 0;
   logic [31:0] acc_q[$];

   bit mem_const = 1'b1;
   bit lat_rand  = 1'b0;
   int lat_fixed = 0;
   bit spur_en   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem_const ? 32'h0000_0013 : (a * 32'h9E37_79B1) + 32'h0000_0013;
   endfunction

   // one clock cycle: drive inputs, check the request, advance the model, check the buffer
   task automatic step(input bit stall, input bit redir, input logic [31:0] rpc, input bit ready);
      bit          deliver;
      bit          spur;
      logic [31:0] d_addr;
      int          d_epoch;
      bit          exp_req;
      deliver = 1'b0;
      spur    = 1'b0;
      d_addr  = '0;
      d_epoch = 0;
      if (pend && pend_dly == 0) begin
         deliver = 1'b1;
         d_addr  = pend_addr;
         d_epoch = pend_epoch;
         pend    = 1'b0;
      end else if (pend) begin
         pend_dly--;
      end else if (spur_en && $urandom_range(0, 9) == 0) begin
         spur = 1'b1;
      end
      i_stall       = stall;
      i_redirect    = redir;
      i_redirect_pc = rpc;
      i_imem_ready  = ready;
      i_imem_rvalid = deliver | spur;
      i_imem_rdata  = deliver ? mem_word(d_addr) : $urandom;
      #1;
      exp_req = !pend && !deliver && (!m_valid || !stall) && !redir;
      check("imem_req", {31'b0, o_imem_req}, {31'b0, exp_req});
      if (o_imem_req) check("imem_addr", o_imem_addr, exp_pc);
      if (exp_req && ready) begin
         pend       = 1'b1;
         pend_addr  = exp_pc;
         pend_epoch = epoch;
         pend_dly   = lat_rand ? int'($urandom_range(0, 2)) : lat_fixed;
         acc_q.push_back(exp_pc);
      end
      if (redir) begin
         epoch++;
         exp_pc  = rpc & ~32'd3;
         m_valid = 1'b0;
      end else if (deliver && d_epoch == epoch) begin
         m_valid = 1'b1;
         m_pc    = d_addr;
         m_instr = mem_word(d_addr);
         exp_pc  = d_addr + 32'd4;
      end else if (m_valid && !stall) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("validF", {31'b0, o_validF}, {31'b0, m_valid});
      if (m_valid) begin
         check("PCF", PCF, m_pc);
         check("instrF", instrF, m_instr);
         check("PCPLUS4F", PCPLUS4F, m_pc + 32'd4);
      end
   endtask

   // asynchronous reset asserted between edges; outputs must clear without a clock
   task automatic do_reset();
      i_rst         = 1'b1;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_imem_rvalid = 1'b0;
      #1;
      check("rst_validF", {31'b0, o_validF}, 32'd0);
      check("rst_instrF", instrF, 32'd0);
      check("rst_PCF", PCF, 32'd0);
      check("rst_PCPLUS4F", PCPLUS4F, 32'd0);
      check("rst_req", {31'b0, o_imem_req}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      i_rst   = 1'b0;
      pend    = 1'b0;
      m_valid = 1'b0;
      exp_pc  = RPC;
      epoch++;
   endtask

   initial begin
      logic [31:0] tgt;
      #1;
      do_reset();

      // straight-line fetch, constant memory, 1-cycle latency
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("first_valid", {31'b0, o_validF}, 32'd1);
      check("first_PCF", PCF, 32'h0);
      check("first_PCPLUS4F", PCPLUS4F, 32'h4);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
      check("acc_n", acc_q.size(), 32'd3);
      check("acc0", acc_q[0], 32'h0);
      check("acc1", acc_q[1], 32'h4);
      check("acc2", acc_q[2], 32'h8);
      mem_const = 1'b0;

      // stall with buffer valid at 0x8
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
      check("stall_PCF", PCF, 32'h8);
      step(0, 0, 0, 1);
      check("after_stall_addr", acc_q[$], 32'hC);
      step(0, 0, 0, 1);

      // redirect while the 0x10 read is in flight
      lat_fixed = 1;
      step(0, 0, 0, 1);
      check("pending_addr", acc_q[$], 32'h10);
      lat_fixed = 0;
      step(0, 1, 32'h103, 1);
      check("redir_valid", {31'b0, o_validF}, 32'd0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("redir_addr", acc_q[$], 32'h100);
      step(0, 0, 0, 1);
      check("redir_PCF", PCF, 32'h100);

      // redirect together with stall on a valid buffer
      step(1, 1, 32'h200, 1);
      check("stall_redir_valid", {31'b0, o_validF}, 32'd0);
      step(1, 0, 0, 1);
      check("stall_redir_addr", acc_q[$], 32'h200);
      step(0, 0, 0, 1);

      // wrap at the top of the address space
      step(0, 1, 32'hFFFF_FFFE, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("wrap_PCF", PCF, 32'hFFFF_FFFC);
      check("wrap_PCPLUS4F", PCPLUS4F, 32'h0);
      step(0, 0, 0, 1);
      check("wrap_addr", acc_q[$], 32'h0);
      step(0, 0, 0, 1);

      // reset in the middle of a slow read
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      lat_fixed = 2;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      do_reset();
      lat_fixed = 0;
      step(0, 0, 0, 1);
      check("post_rst_addr", acc_q[$], RPC);

      // randomized traffic
      lat_rand = 1'b1;
      spur_en  = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
         step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 9) < 7);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
